countdown_display: RTL and testbench
====================================

Name: countdown_display

Overview:
- Downstream stage of the traffic-light controller. Consumes its 8-bit countdown value and the red/yellow/green lamp outputs.
- Converts the binary count to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a 3-digit multiplexed seven-segment display with leading-zero blanking, plus a 2-bit phase code for the lamp indicator.

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot in the display scan (legal range >= 2)
BLINK_DIV, 250000, clk cycles per blink half-period (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
clock_val  input  8  countdown value from the traffic-light controller, unsigned 0..255
red  input  1  red lamp state
yellow  input  1  yellow lamp state
green  input  1  green lamp state
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
an  output  3  digit enables, one-hot active-low; an[0] = ones, an[2] = hundreds; registered
phase  output  2  00 none, 01 red, 10 yellow, 11 green; registered
busy  output  1  high while the BCD conversion is running

Behaviour:
- Reset (sampled on rst=1 at a clk edge): seg=7'h00, an=3'b110, phase=2'b00, busy=0; BCD register=000; last_val=0; scan counter=0; digit index=0; conversion FSM=IDLE; force flag=1.
- Conversion FSM states: IDLE, SHIFT, LOAD.
  - IDLE -> SHIFT when (clock_val != last_val) or force flag set. On that edge: latch clock_val into the shift register and last_val, clear the force flag, zero the 12-bit scratch BCD, set busy=1.
  - SHIFT runs exactly 8 cycles. Each cycle: add 3 to every scratch nibble >= 5, then shift {bcd,bin} left by 1.
  - LOAD (1 cycle): copy scratch to the BCD register, busy=0, go to IDLE.
  - Latency from an input change to the BCD register update is 10 clk edges: capture, 8 shifts, load.
- clock_val changes during SHIFT or LOAD are ignored. On return to IDLE the input is compared against last_val again, so the final stable value is always converted. The displayed value is never torn.
- Scan: scan_cnt counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0->1->2->0. an and seg update on the same edge, so the digit select and its segment data are always coherent.
- Segment encoding 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. BCD nibbles above 9 cannot occur; map them to 7'h00.
- Blanking:
  - Hundreds digit: seg=0 when hundreds=0.
  - Tens digit: seg=0 when hundreds=0 and tens=0.
  - Ones digit: always shown, so a value of 0 displays "0".
  - When red, yellow and green are all 0, every digit shows seg=0 while an keeps scanning.
- phase priority: red > yellow > green (red=1 gives 01 regardless of the others). phase is registered, so it lags its inputs by 1 cycle.
- A reset asserted mid-conversion or mid-scan aborts the operation immediately and restores the reset values above. The first conversion after reset is forced, even when clock_val=0.

Optional Feature:
- Macro COUNTDOWN_BLINK_EN.
- Defined:
  - A free-running blink counter of BLINK_DIV cycles toggles a blink flag; the counter and flag reset to 0.
  - While yellow=1 and blink flag=1, all seg=0. While yellow=0, the flag is held at 0 and the counter is held at reset.
- Not defined: no blink counter is built; seg is never masked by yellow.

Test Plan:
- Reset, then clock_val=60 with green=1 -> busy high for 9 cycles; BCD=0x060 on the 10th edge; scan with SCAN_DIV=4 shows an=110 seg=3F, an=101 seg=7D, an=011 seg=00; phase=11.
- clock_val=255, red=1 -> digits 2,5,5 (5B,6D,6D); phase=01 (also with green=1 held simultaneously).
- clock_val=5 -> hundreds and tens blank (seg=00), ones seg=6D; clock_val=0 -> ones seg=3F.
- clock_val 60->10 on the 3rd SHIFT cycle -> the 60 conversion completes (BCD=060), then the 10 conversion starts in IDLE; final BCD=010 with no intermediate value.
- All lamps 0, clock_val=42 -> seg=00 on every digit, an keeps rotating 110/101/011; assert rst mid-SHIFT -> next cycle busy=0, BCD=000, an=110.
- COUNTDOWN_BLINK_EN with BLINK_DIV=8, yellow=1, clock_val=5 -> seg alternates 6D / 00 every 8 cycles on the ones digit; yellow=0 -> no masking.

Source files
------------

// File: rtl/countdown_display.sv
// Countdown display: double-dabble BCD conversion of an 8-bit count driving a 3-digit muxed 7-seg display.
// Optional macro COUNTDOWN_BLINK_EN blanks the segments at BLINK_DIV cadence while yellow is lit.
module countdown_display #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] clock_val,
   input  logic       red,
   input  logic       yellow,
   input  logic       green,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic [1:0] phase,
   output logic       busy
);

   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t      state_q, state_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] scr_q, scr_d;
   logic [11:0] bcd_q, bcd_d;
   logic [7:0]  last_q, last_d;
   logic        force_q, force_d;
   logic        busy_q, busy_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [11:0] adj;

   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [1:0]  idx_q, idx_d;
   logic [6:0]  seg_q, seg_d;
   logic [2:0]  an_q, an_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  nib;
   logic        blank;
   logic        blink_mask;

   function automatic logic [6:0] enc7(input logic [3:0] d);
      case (d)
         4'd0:    enc7 = 7'h3F;
         4'd1:    enc7 = 7'h06;
         4'd2:    enc7 = 7'h5B;
         4'd3:    enc7 = 7'h4F;
         4'd4:    enc7 = 7'h66;
         4'd5:    enc7 = 7'h6D;
         4'd6:    enc7 = 7'h7D;
         4'd7:    enc7 = 7'h07;
         4'd8:    enc7 = 7'h7F;
         4'd9:    enc7 = 7'h6F;
         default: enc7 = 7'h00;
      endcase
   endfunction

   // Conversion FSM and datapath; input changes mid-conversion are picked up on return to IDLE.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      bcd_d   = bcd_q;
      last_d  = last_q;
      force_d = force_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      adj     = scr_q;
      for (int i = 0; i < 3; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         IDLE: begin
            if ((clock_val != last_q) || force_q) begin
               state_d = SHIFT;
               bin_d   = clock_val;
               last_d  = clock_val;
               force_d = 1'b0;
               scr_d   = 12'h000;
               busy_d  = 1'b1;
               cnt_d   = 3'd0;
            end
         end
         SHIFT: begin
            {scr_d, bin_d} = {adj[10:0], bin_q, 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = LOAD;
         end
         LOAD: begin
            bcd_d   = scr_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Digit select and segment data are derived from the same next index so they never disagree.
   always_comb begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      idx_d  = idx_q;
      if (scan_q == SCAN_LAST) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      nib   = 4'd0;
      blank = 1'b1;
      an_d  = 3'b110;
      case (idx_d)
         2'd0: begin
            nib = bcd_q[3:0]; blank = 1'b0; an_d = 3'b110;
         end
         2'd1: begin
            nib = bcd_q[7:4]; blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0); an_d = 3'b101;
         end
         2'd2: begin
            nib = bcd_q[11:8]; blank = (bcd_q[11:8] == 4'd0); an_d = 3'b011;
         end
         default: begin
            nib = 4'd0; blank = 1'b1; an_d = 3'b110;
         end
      endcase
      seg_d = (blank || !(red || yellow || green) || blink_mask) ? 7'h00 : enc7(nib);
      if (red)         phase_d = 2'b01;
      else if (yellow) phase_d = 2'b10;
      else if (green)  phase_d = 2'b11;
      else             phase_d = 2'b00;
   end

`ifdef COUNTDOWN_BLINK_EN
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_q;

   always_ff @(posedge clk) begin
      if (rst || !yellow) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt_q <= '0;
         blink_q     <= ~blink_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

   assign blink_mask = yellow && blink_q;
`else
   assign blink_mask = (BLINK_DIV < 1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= 8'd0;
         scr_q   <= 12'h000;
         bcd_q   <= 12'h000;
         last_q  <= 8'd0;
         force_q <= 1'b1;
         busy_q  <= 1'b0;
         cnt_q   <= 3'd0;
         scan_q  <= '0;
         idx_q   <= 2'd0;
         seg_q   <= 7'h00;
         an_q    <= 3'b110;
         phase_q <= 2'b00;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         bcd_q   <= bcd_d;
         last_q  <= last_d;
         force_q <= force_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         phase_q <= phase_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign phase = phase_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display: vector table for digit/phase decoding plus hand sequences for latency,
// mid-conversion input change, reset abort and (with COUNTDOWN_BLINK_EN) yellow blinking.
module tb_countdown_display;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 8;
`ifdef COUNTDOWN_BLINK_EN
   localparam bit BLINK_BUILD = 1'b1;
`else
   localparam bit BLINK_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] clock_val;
   logic       red, yellow, green;
   logic [6:0] seg;
   logic [2:0] an;
   logic [1:0] phase;
   logic       busy;

   int checks = 0;
   int errors = 0;

   countdown_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk(clk), .rst(rst), .clock_val(clock_val), .red(red), .yellow(yellow), .green(green),
      .seg(seg), .an(an), .phase(phase), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] val;
      logic       r, y, g;
      logic [6:0] h, t, o;
      logic [1:0] ph;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Watch the scan for n cycles: each digit slot must carry its expected segments, and the enables must rotate.
   task automatic check_scan(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o, input int n);
      logic [2:0] prev;
      logic [2:0] nxt;
      prev = an;
      for (int k = 0; k < n; k++) begin
         tick();
         case (an)
            3'b110:  check("seg_ones", int'(seg), int'(o));
            3'b101:  check("seg_tens", int'(seg), int'(t));
            3'b011:  check("seg_hundreds", int'(seg), int'(h));
            default: check("an_onehot", int'(an), 3'b110);
         endcase
         if (an != prev) begin
            nxt = (prev == 3'b110) ? 3'b101 : (prev == 3'b101) ? 3'b011 : 3'b110;
            check("an_rotation", int'(an), int'(nxt));
         end
         prev = an;
      end
   endtask

   initial begin
      vecs[0] = '{8'd60,  1'b0, 1'b0, 1'b1, 7'h00, 7'h7D, 7'h3F, 2'b11};
      vecs[1] = '{8'd255, 1'b1, 1'b0, 1'b1, 7'h5B, 7'h6D, 7'h6D, 2'b01};
      vecs[2] = '{8'd5,   1'b1, 1'b0, 1'b0, 7'h00, 7'h00, 7'h6D, 2'b01};
      vecs[3] = '{8'd0,   1'b0, 1'b1, 1'b0, 7'h00, 7'h00, 7'h3F, 2'b10};
      vecs[4] = '{8'd42,  1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00, 2'b00};
      vecs[5] = '{8'd100, 1'b0, 1'b0, 1'b1, 7'h06, 7'h3F, 7'h3F, 2'b11};
      vecs[6] = '{8'd99,  1'b0, 1'b1, 1'b1, 7'h00, 7'h6F, 7'h6F, 2'b10};
      vecs[7] = '{8'd207, 1'b0, 1'b0, 1'b1, 7'h5B, 7'h3F, 7'h07, 2'b11};
      vecs[8] = '{8'd10,  1'b0, 1'b0, 1'b1, 7'h00, 7'h06, 7'h3F, 2'b11};
      vecs[9] = '{8'd180, 1'b1, 1'b1, 1'b0, 7'h06, 7'h7F, 7'h3F, 2'b01};

      // Reset values
      rst = 1'b1; clock_val = 8'd60; red = 1'b0; yellow = 1'b0; green = 1'b1;
      tick(); tick();
      check("rst_seg", int'(seg), 7'h00);
      check("rst_an", int'(an), 3'b110);
      check("rst_phase", int'(phase), 2'b00);
      check("rst_busy", int'(busy), 0);

      // First conversion: busy for 9 cycles, BCD loaded on the 10th edge
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("busy_edge%0d", k), int'(busy), (k <= 9) ? 1 : 0);
         if (k == 10) check("bcd_latency", int'(dut.bcd_q), 12'h060);
      end
      tick();
      check_scan(7'h00, 7'h7D, 7'h3F, 12);
      check("phase_green", int'(phase), 2'b11);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         if (!(BLINK_BUILD && vecs[i].y)) begin
            clock_val = vecs[i].val; red = vecs[i].r; yellow = vecs[i].y; green = vecs[i].g;
            for (int k = 0; k < 12; k++) tick();
            check_scan(vecs[i].h, vecs[i].t, vecs[i].o, 12);
            check($sformatf("phase_v%0d", i), int'(phase), int'(vecs[i].ph));
            check($sformatf("busy_idle_v%0d", i), int'(busy), 0);
         end
      end

      // Input change during SHIFT: 60 completes untouched, then 10 converts
      clock_val = 8'd0; red = 1'b0; yellow = 1'b0; green = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      check("pre_bcd", int'(dut.bcd_q), 12'h000);
      clock_val = 8'd60;
      tick(); tick(); tick();
      clock_val = 8'd10;
      for (int k = 4; k <= 20; k++) begin
         tick();
         if (k <= 9)       check($sformatf("bcd_hold_e%0d", k), int'(dut.bcd_q), 12'h000);
         else if (k <= 19) check($sformatf("bcd_60_e%0d", k), int'(dut.bcd_q), 12'h060);
         else              check("bcd_10_final", int'(dut.bcd_q), 12'h010);
      end
      tick();
      check_scan(7'h00, 7'h06, 7'h3F, 12);

      // Reset mid-SHIFT aborts; first conversion afterwards is forced even for 0
      red = 1'b0; yellow = 1'b0; green = 1'b0; clock_val = 8'd42;
      tick(); tick(); tick();
      check("busy_mid_shift", int'(busy), 1);
      rst = 1'b1;
      tick();
      check("abort_busy", int'(busy), 0);
      check("abort_bcd", int'(dut.bcd_q), 12'h000);
      check("abort_an", int'(an), 3'b110);
      check("abort_seg", int'(seg), 7'h00);
      check("abort_phase", int'(phase), 2'b00);
      rst = 1'b0; clock_val = 8'd0; green = 1'b1;
      tick();
      check("forced_busy", int'(busy), 1);
      for (int k = 0; k < 11; k++) tick();
      check("forced_bcd", int'(dut.bcd_q), 12'h000);
      check_scan(7'h00, 7'h00, 7'h3F, 12);

`ifdef COUNTDOWN_BLINK_EN
      // Yellow blink: ones digit toggles 6D/00 each BLINK_DIV cycles
      clock_val = 8'd5; yellow = 1'b0; green = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      yellow = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         tick();
         if (an == 3'b110)
            check($sformatf("blink_e%0d", k), int'(seg), (((k - 1) / BLINK_DIV) % 2 == 1) ? 7'h00 : 7'h6D);
      end
      yellow = 1'b0;
      tick();
      check_scan(7'h00, 7'h00, 7'h6D, 24);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
